// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared FSM state type and counter sizing for mult_arbiter
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    // The counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_arbiter_engine.sv
// rtl/mult_arbiter_engine.sv - WIDTH-cycle unsigned shift-add multiplier engine
module shift_add_engine
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_sum;

    // acc_sum is the accumulator after the current step, so the final product
    // is visible in the same cycle that done is high.
    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            count_d  = CNT_LOAD;
        end else if (count_q != '0) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign product = acc_sum;
    assign done    = (count_q == CNT_ONE);

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one shift-add multiplier among N requesters
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_a,
    input  logic [N*WIDTH-1:0]   req_b,
    output logic [N-1:0]         req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     idx_v;
    logic               grant;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               eng_load;
    logic               eng_done;
    logic [2*WIDTH-1:0] eng_product;

    // Scan from the far end back toward rr_ptr so the nearest valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_v  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_v = IDW'((int'(rr_ptr_q) + k) % N);
            if (req_valid[idx_v]) begin
                found  = 1'b1;
                winner = idx_v;
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == winner) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant     = found && (state_q == ST_IDLE);
    assign req_ready = grant ? (N'(1) << winner) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        busy_d      = busy_q;
        eng_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    eng_load = 1'b1;
                    id_d     = winner;
                    rr_ptr_d = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
                    busy_d   = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (eng_done) begin
                    res_data_d  = eng_product;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
        end
    end

    shift_add_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (eng_load),
        .a       (op_a),
        .b       (op_b),
        .product (eng_product),
        .done    (eng_done)
    );

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one shift-add unsigned multiplier engine among N requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, runs the WIDTH-cycle engine and returns the product tagged with the requester index over a valid/ready result port. It sits between several client blocks and a single multiplier, so the multiplier area is not duplicated.

## Interface
- Reset: one clock; reset is asynchronous and active-low.
- `WIDTH`, default 8: operand width; product is 2*WIDTH.
- `N`, default 4: number of requesters, minimum 2.
- `IDW`, default $clog2(N): requester-index width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N  bit i: requester i presents operands.
- `req_a`  in  N*WIDTH  multiplicands; slice i is bits [i*WIDTH +: WIDTH].
- `req_b`  in  N*WIDTH  multipliers; same slicing.
- `req_ready`  out  N  one-hot grant; bit i high means requester i is accepted at this edge.
- `res_valid`  out  1  product available.
- `res_ready`  in  1  consumer accepts product.
- `res_data`  out  2*WIDTH  unsigned product.
- `res_id`  out  IDW  index of the requester that owns `res_data`.
- `busy`  out  1  high in BUSY and DONE.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- Reset values: `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0, `rr_ptr`=0, engine registers=0.
- IDLE:
  - Winner = first i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping modulo N.
  - `req_ready` is combinational: one-hot of the winner in IDLE, all zero in every other state.
  - On the edge with valid&ready: latch the winner's a and b into the engine, latch the winner index, set `rr_ptr` = winner+1 mod N, then go to BUSY.
  - If no request is valid, stay in IDLE and leave `rr_ptr` unchanged.
- BUSY:
  - The engine performs one shift-add step per cycle: if multiplier LSB is 1, acc += multiplicand (2*WIDTH bits, no overflow possible); multiplicand <<= 1; multiplier >>= 1; count decrements.
  - `count` is $clog2(WIDTH+1) bits, loaded with WIDTH.
  - On the step where `count` goes to 0: register acc into `res_data`, the index into `res_id`, set `res_valid`=1, and go to DONE.
- DONE:
  - Hold `res_valid`, `res_data` and `res_id` stable while `res_ready`=0.
  - On the edge with `res_ready`=1: clear `res_valid` and go to IDLE. `res_data` and `res_id` keep their last value.
- Requesters may change `req_a`/`req_b` freely after their grant edge; the operands are already captured.
- Changes to `req_valid` during BUSY/DONE have no effect until the next IDLE.
- Operands of 0 are legal and still take the full WIDTH cycles, giving product 0.
- Reset asserted mid-operation: the block immediately enters the reset state, the in-flight product is discarded and no `res_valid` pulse is emitted.

## Timing
- Grant edge T, in IDLE. BUSY covers cycles T+1 through T+WIDTH.
- `res_valid` rises after edge T+WIDTH, so latency is WIDTH cycles from accept to result.
- With `res_ready` tied high, DONE lasts 1 cycle. The next grant edge is then T+WIDTH+2, so peak throughput is one product per WIDTH+2 cycles.
- Fairness: with all N requesters continuously valid, grants go in order 0,1,…,N-1,0,…; each requester waits at most N-1 operations.
- The result port does not use a combinational path from `res_ready` to `res_valid`.

## Structure
- Shared package holds the state enum (IDLE/BUSY/DONE) and the `clog2`-based count-width constant.
- Sub-module `shift_add_engine`, parameter WIDTH:
  - Inputs: `clk`, `rst_n`, `load`, `a`, `b`.
  - Outputs: `product`, `done` (1-cycle pulse).
  - Contains acc, the shift registers and the counter.
- `mult_arbiter` holds the FSM, the round-robin pointer and priority search, the index register and the result registers.

## Test plan
- Single request: requester 0, a=13, b=11, `res_ready`=1 → `req_ready`=0001 for one cycle; after 8 cycles `res_valid`=1, `res_data`=143, `res_id`=0.
- Max operands: requester 2, a=255, b=255 → `res_data`=65025, `res_id`=2. Zero operand: a=0, b=200 → `res_data`=0 after 8 cycles.
- All four valid continuously, each with a distinct pair (e.g. a=i+1, b=10) → results in `res_id` order 0,1,2,3,0, correct products, spacing of 10 cycles between grants.
- Backpressure: hold `res_ready`=0 for 5 cycles in DONE → `res_valid`, `res_data` and `res_id` stable, `req_ready`=0 throughout; no new grant until the cycle after `res_ready`=1.
- Rotation: `rr_ptr`=3 with requesters 1 and 3 valid → grant 3, then 1.
- Reset mid-BUSY: drop `rst_n` at cycle 4 of a 7×9 operation → all outputs at reset values, no `res_valid`; a new request after release returns the correct product and `res_id`.
